// File: rtl/rs232_loop_tester.sv
// Host end of an RS-232 echo loop: sends an incrementing run of 8N1 bytes on TXD_o
// and checks that each one comes back unchanged on RXD_i.
module rs232_loop_tester #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] len_i,
    input  logic [7:0] seed_i,
    output logic       TXD_o,
    input  logic       RXD_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] err_cnt_o,
    output logic       timeout_o,
    output logic [4:0] dbg_state_o
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_ECHO, S_CHECK, S_FINISH} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    state_t           state;
    rx_state_t        rx_state;

    logic             rx_s1, rx_s2, rx_s3;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic             rx_done;
    logic [7:0]       rx_data;
    logic             rx_ferr;

    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [7:0]       tx_byte;
    logic [8:0]       bytes_left;
    logic [TO_W-1:0]  to_cnt;
    logic             got_echo;
    logic [7:0]       echo_byte;
    logic             echo_ferr;

    logic             in_window, accept_echo, spurious, check_err, timeout_hit;
    logic [8:0]       err_sum;
    logic [7:0]       err_next;

    assign dbg_state_o = {rx_state, state};

    // Free-running receiver; rx_done is a one-cycle pulse with rx_data/rx_ferr valid alongside.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
            rx_data  <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1   <= RXD_i;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            rx_done <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bits == 3'd7) rx_state <= R_STOP;
                        else                 rx_bits  <= rx_bits + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_done  <= 1'b1;
                        rx_data  <= rx_shift;
                        rx_ferr  <= !rx_s2;
                        rx_state <= R_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Echo window: the stop bit of the current byte through the end of WAIT_ECHO.
    always_comb begin
        in_window   = (state == S_SEND && tx_bit == 4'd9) || state == S_WAIT_ECHO;
        accept_echo = rx_done && in_window && !got_echo;
        spurious    = rx_done && busy_o && !accept_echo;
        check_err   = (state == S_CHECK) && ((echo_byte != tx_byte) || echo_ferr);
        timeout_hit = (state == S_WAIT_ECHO) && !accept_echo && (to_cnt == TO_LAST);
        err_sum     = {1'b0, err_cnt_o} + 9'(spurious) + 9'(check_err) + 9'(timeout_hit);
        err_next    = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // start_i is a request taken only when busy_o is low (IDLE); it is dropped otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            TXD_o      <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_cnt_o  <= '0;
            timeout_o  <= 1'b0;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_byte    <= '0;
            bytes_left <= '0;
            to_cnt     <= '0;
            got_echo   <= 1'b0;
            echo_byte  <= '0;
            echo_ferr  <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            err_cnt_o <= err_next;
            if (accept_echo) begin
                got_echo  <= 1'b1;
                echo_byte <= rx_data;
                echo_ferr <= rx_ferr;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        bytes_left <= (len_i == 8'd0) ? 9'd256 : {1'b0, len_i};
                        tx_byte    <= seed_i;
                        err_cnt_o  <= '0;
                        pass_o     <= 1'b0;
                        timeout_o  <= 1'b0;
                        busy_o     <= 1'b1;
                        TXD_o      <= 1'b0;
                        tx_bit     <= '0;
                        tx_cnt     <= '0;
                        got_echo   <= 1'b0;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            to_cnt <= '0;
                            state  <= (got_echo || accept_echo) ? S_CHECK : S_WAIT_ECHO;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            TXD_o  <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_WAIT_ECHO: begin
                    if (accept_echo) begin
                        state <= S_CHECK;
                    end else if (timeout_hit) begin
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        pass_o    <= 1'b0;
                        state     <= S_FINISH;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    got_echo <= 1'b0;
                    if (bytes_left == 9'd1) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (err_next == 8'd0);
                        state  <= S_FINISH;
                    end else begin
                        bytes_left <= bytes_left - 9'd1;
                        tx_byte    <= tx_byte + 8'd1;
                        TXD_o      <= 1'b0;
                        tx_bit     <= '0;
                        tx_cnt     <= '0;
                        state      <= S_SEND;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_loop_tester.sv
// Bench for rs232_loop_tester: decodes TXD, echoes bytes back (optionally corrupted)
// and scores wire bytes and end-of-run results against expected queues.
module tb_rs232_loop_tester;

    localparam int CPB = 8;

    logic       clk, rst, start;
    logic [7:0] len, seed;
    logic       txd, rxd, busy, done, pass, timeout;
    logic [7:0] err_cnt;
    logic [4:0] dbg_state;

    logic       loop_wire, rxd_drv, echo_en, ignore_wire;
    int         checks, errors, frames_seen, cyc;
    int         echo_num, corrupt_idx, corrupt_kind, glitch_idx;

    logic [7:0] exp_wire_q[$];
    logic [9:0] exp_res_q[$];
    logic [7:0] echo_q[$];

    assign rxd = loop_wire ? txd : rxd_drv;

    rs232_loop_tester #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(40)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .seed_i(seed),
        .TXD_o(txd), .RXD_i(rxd), .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_cnt_o(err_cnt), .timeout_o(timeout), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // wire monitor: decodes TXD frames and scores them against exp_wire_q
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        logic [7:0] e;
        frames_seen = 0;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = txd;
                if (!ignore_wire) begin
                    frames_seen++;
                    check("wire_stop", stop_bit, 1);
                    if (exp_wire_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wire_extra actual=%0h expected=none", b);
                    end else begin
                        e = exp_wire_q.pop_front();
                        check("wire_byte", b, e);
                    end
                    if (echo_en) echo_q.push_back(b);
                end
            end
        end
    end

    // echo driver: replays decoded bytes on RXD with optional glitch/corruption
    initial begin
        logic [7:0] eb;
        logic       es;
        rxd_drv = 1'b1;
        forever begin
            @(negedge clk);
            if (echo_q.size() != 0) begin
                eb = echo_q.pop_front();
                if (echo_num == glitch_idx) begin
                    repeat (CPB) @(negedge clk);
                    rxd_drv = 1'b0;
                    @(negedge clk);
                    rxd_drv = 1'b1;
                    repeat (3 * CPB) @(negedge clk);
                end
                if (echo_num == corrupt_idx && corrupt_kind == 0) eb[0] = ~eb[0];
                es = !(echo_num == corrupt_idx && corrupt_kind == 1);
                rxd_drv = 1'b0;
                repeat (CPB) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rxd_drv = eb[i];
                    repeat (CPB) @(negedge clk);
                end
                rxd_drv = es;
                repeat (CPB) @(negedge clk);
                rxd_drv = 1'b1;
                echo_num++;
            end
        end
    end

    // result monitor: scores every done pulse against exp_res_q {pass, timeout, err}
    initial begin
        logic [9:0] r;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    r = exp_res_q.pop_front();
                    check("res_pass", pass, r[9]);
                    check("res_timeout", timeout, r[8]);
                    check("res_err_cnt", err_cnt, r[7:0]);
                    check("res_busy_low", busy, 0);
                end
            end
        end
    end

    task automatic run(input logic [7:0] l, input logic [7:0] s, input logic exp_pass,
                       input logic exp_to, input logic [7:0] exp_err, input int n_wire,
                       input bit poke, output int lat);
        int         t0, nb;
        bit         seen;
        logic [7:0] b;
        b = s;
        for (int i = 0; i < n_wire; i++) begin
            exp_wire_q.push_back(b);
            b = b + 8'd1;
        end
        exp_res_q.push_back({exp_pass, exp_to, exp_err});
        nb = (l == 8'd0) ? 256 : int'(l);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_txd", txd, 1);
        start = 1'b1;
        len   = l;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        len   = 8'hFF;
        seed  = 8'h00;
        check("accept_busy", busy, 1);
        check("accept_txd", txd, 0);
        t0 = cyc;
        if (poke) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            len   = 8'd1;
            seed  = 8'h99;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < nb * 40 * CPB + 600 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        check("done_seen", seen, 1);
        repeat (20) @(negedge clk);
        check("wire_q_empty", exp_wire_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"}, txd, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int lat, f0;
        checks = 0;      errors = 0;
        rst = 1'b1;      start = 1'b0;    len = '0;      seed = '0;
        loop_wire = 1'b0; echo_en = 1'b0; ignore_wire = 1'b0;
        echo_num = 0;    corrupt_idx = -1; corrupt_kind = 0; glitch_idx = -1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_dbg_state", dbg_state, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // direct wire loopback, with an ignored start request mid-run
        loop_wire = 1'b1;
        run(8'd4, 8'h41, 1'b1, 1'b0, 8'd0, 4, 1'b1, lat);

        // bench echo, sequence wraps FE, FF, 00
        loop_wire = 1'b0; echo_en = 1'b1; echo_num = 0;
        run(8'd3, 8'hFE, 1'b1, 1'b0, 8'd0, 3, 1'b0, lat);

        // bit 0 of the second echo inverted
        echo_num = 0; corrupt_idx = 1; corrupt_kind = 0;
        run(8'd4, 8'h10, 1'b0, 1'b0, 8'd1, 4, 1'b0, lat);

        // first echo returned with stop bit 0
        echo_num = 0; corrupt_idx = 0; corrupt_kind = 1;
        run(8'd2, 8'h5A, 1'b0, 1'b0, 8'd1, 2, 1'b0, lat);

        // one-cycle low glitch in the echo wait, then the real echo
        echo_num = 0; corrupt_idx = -1; glitch_idx = 0;
        run(8'd2, 8'h80, 1'b1, 1'b0, 8'd0, 2, 1'b0, lat);
        glitch_idx = -1;

        // no echo at all: timeout after 10 + 40 bit periods, one frame only
        echo_en = 1'b0;
        run(8'd5, 8'h33, 1'b0, 1'b1, 8'd1, 1, 1'b0, lat);
        check("timeout_latency", lat, 50 * CPB);

        // reset in the middle of the second frame
        loop_wire = 1'b1;
        exp_wire_q.push_back(8'h20);
        f0 = frames_seen;
        @(negedge clk);
        start = 1'b1; len = 8'd4; seed = 8'h20;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 * CPB && frames_seen == f0; k++) @(negedge clk);
        check("rst_first_frame", frames_seen, f0 + 1);
        repeat (20) @(negedge clk);
        check("rst_busy_before", busy, 1);
        ignore_wire = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        ignore_wire = 1'b0;
        check("midrst_wire_q", exp_wire_q.size(), 0);

        // len 0 means 256 bytes
        run(8'd0, 8'hC0, 1'b1, 1'b0, 8'd0, 256, 1'b0, lat);

        repeat (20) @(negedge clk);
        check("res_q_empty", exp_res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs232_loop_tester.md
# rs232_loop_tester

Self-checking RS-232 link exerciser that acts as the host end of the serial echo loop: it transmits a run of 8N1 bytes on its TXD output and checks that each byte returns unchanged on its RXD input. It connects to the echo top by wiring `TXD_o` to the top's `RXD_i` and the top's `TXD_o` to this block's `RXD_i`. It is used in simulation benches and as an on-board BIST for the receiver/transmitter pair.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud); must be ≥ 4.
- `TIMEOUT_BITS`, default 40: echo timeout, in bit periods.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  one-cycle request to begin a run; accepted only in IDLE.
- `len_i`  in  8  bytes per run; 0 means 256. Sampled when a run is accepted.
- `seed_i`  in  8  first byte of the run. Sampled when a run is accepted.
- `TXD_o`  out  1  serial output; idles high.
- `RXD_i`  in  1  serial input; asynchronous.
- `busy_o`  out  1  high from run acceptance until `done_o`.
- `done_o`  out  1  one-cycle pulse at the end of a run.
- `pass_o`  out  1  run completed with `err_cnt_o` = 0 and no timeout.
- `err_cnt_o`  out  8  mismatches, framing errors and spurious frames; saturates at 255.
- `timeout_o`  out  1  run was aborted by an echo timeout.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Byte sequence: `seed_i`, then previous byte + 1 mod 256 (0xFF wraps to 0x00).
- FSM:
  - IDLE: on `start_i`, latch `len_i`/`seed_i`; clear `err_cnt_o`, `pass_o` and `timeout_o`; → SEND.
  - SEND: serialize the current byte. The echo window opens at the start of the stop bit. At the end of the stop bit, → WAIT_ECHO, unless the echo was already consumed, in which case → CHECK.
  - WAIT_ECHO: the timeout counter runs. A received frame → CHECK. If the counter reaches `TIMEOUT_BITS*CLKS_PER_BIT` first, increment the error count, set `timeout_o`, → FINISH.
  - CHECK: if the received byte differs from the sent byte, or the frame had a framing error, increment `err_cnt_o`. If this was the last byte → FINISH; else advance the byte → SEND.
  - FINISH: pulse `done_o`, set `pass_o` = (`err_cnt_o`==0 && !`timeout_o`), → IDLE.
- Receiver:
  - Always running; `RXD_i` passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked at `CLKS_PER_BIT/2`; if it is high, the event is a glitch and the receiver returns to idle without producing a frame.
  - Data and stop bits are sampled at bit centres. The frame completes at the stop-bit centre; stop = 0 flags a framing error.
- Frames arriving outside the echo window:
  - While `busy_o` (SEND before the stop bit, or a second frame in one window): discarded and counted as an error.
  - In IDLE: silently discarded.
- Error counter saturates at 255 and never wraps.
- `start_i` while busy is ignored.

## Timing
- Reset values: `TXD_o`=1, `busy_o`=0, `done_o`=0, `pass_o`=0, `err_cnt_o`=0, `timeout_o`=0. The FSM and receiver go to idle.
- Asserting `rst_i` mid-run aborts the run. All outputs take their reset values on the next edge, and no `done_o` is produced.
- `start_i` accepted at edge N: `busy_o`=1 and the start bit is on `TXD_o` from N+1.
- One byte on the wire takes 10·`CLKS_PER_BIT` cycles. The next start bit follows the echo check by ≤ 2 cycles.
- `done_o` is high for exactly one cycle; `busy_o` falls in the same cycle.
- `pass_o`, `err_cnt_o` and `timeout_o` are valid from `done_o` and hold until the next accepted start.
- RX sampling latency: 2 cycles (synchronizer), which is tolerated within the mid-bit margin.

## Test plan
- Direct wire `TXD_o`→`RXD_i`, `CLKS_PER_BIT`=8, `seed_i`=0x41, `len_i`=4 → bytes 0x41..0x44 on the wire; `done_o` after 4 frames; `pass_o`=1, `err_cnt_o`=0.
- Through the echo top (receiver + transmitter), `seed_i`=0xFE, `len_i`=3 → bytes 0xFE, 0xFF, 0x00 echoed; `pass_o`=1.
- Bench inverts bit 0 of the second echoed byte, `len_i`=4 → `err_cnt_o`=1, `pass_o`=0, `timeout_o`=0.
- `RXD_i` held high, `len_i`=5 → `timeout_o`=1 at 10+40 bit periods after start, `err_cnt_o`=1, a single `done_o`, only one frame sent.
- Echo with stop bit forced 0 → framing error counted. 1-cycle low glitch on `RXD_i` in WAIT_ECHO → no frame and no error.
- `rst_i` asserted mid-frame of byte 2 → `TXD_o`=1 and all outputs reset the next cycle. `start_i` during busy → ignored. `len_i`=0 → 256 bytes, `pass_o`=1.
